// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the instruction-fetch / load-store memory arbiter.
package mem_arb_pkg;

    localparam int unsigned DEF_ADDR_W  = 9;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE,
        MEM,
        RESP
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_IF,
        GNT_LS
    } grant_e;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Counts MEM cycles without mem_ack and flags expiry on the TIMEOUT-th such cycle.
// Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_watchdog #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic active,
    input  logic ack,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    // count holds the number of ack-less MEM cycles already completed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (start) begin
            count <= '0;
        end else if (active && !ack && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = active && !ack && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority (LS over IF) arbiter for the shared data-memory port with a req/ack handshake.
// Optional mem_ack watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall,
    output logic              err
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT must be at least 1");
    end

    arb_state_e        state, state_d;
    grant_e            grant, grant_d;
    logic              grant_now;
    logic              done;
    logic              in_mem;
    logic              expired;
    logic [DATA_W-1:0] resp_data;

    assign in_mem = (state == MEM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            grant <= GNT_NONE;
        end else begin
            state <= state_d;
            grant <= grant_d;
        end
    end

    always_comb begin
        state_d   = state;
        grant_d   = grant;
        grant_now = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (ls_req) begin
                    grant_d   = GNT_LS;
                    state_d   = MEM;
                    grant_now = 1'b1;
                end else if (if_req) begin
                    grant_d   = GNT_IF;
                    state_d   = MEM;
                    grant_now = 1'b1;
                end
            end
            MEM: begin
                if (mem_ack || expired) begin
                    state_d = RESP;
                    done    = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                grant_d = GNT_NONE;
            end
            default: begin
                state_d = IDLE;
                grant_d = GNT_NONE;
            end
        endcase
    end

    // stores and watchdog aborts both complete with zero read data
    assign resp_data = (!mem_ack || mem_we) ? '0 : mem_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            ls_rdata  <= '0;
        end else begin
            if (grant_now) begin
                mem_we    <= ls_req ? ls_we : 1'b0;
                mem_addr  <= ls_req ? ls_addr : if_addr;
                mem_wdata <= ls_req ? ls_wdata : '0;
            end
            if (done) begin
                if (grant == GNT_LS) begin
                    ls_rdata <= resp_data;
                end else begin
                    if_rdata <= resp_data;
                end
            end
        end
    end

    assign mem_req  = in_mem;
    assign if_valid = (state == RESP) && (grant == GNT_IF);
    assign ls_valid = (state == RESP) && (grant == GNT_LS);
    assign stall    = (if_req & ~if_valid) | (ls_req & ~ls_valid);

`ifdef MEM_ARB_TIMEOUT_EN
    logic timed_out;

    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .start   (grant_now),
        .active  (in_mem),
        .ack     (mem_ack),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timed_out <= 1'b0;
        end else if (state == MEM) begin
            timed_out <= expired;
        end else if (state == IDLE) begin
            timed_out <= 1'b0;
        end
    end

    assign err = (state == RESP) && timed_out;
`else
    assign expired = 1'b0;
    assign err     = 1'b0;
`endif

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single data-memory port between instruction fetch (IF) and the load/store path (LS, driven by the decoder's MemRead/MemWrite). Fixed-priority arbiter with a three-state sequencer and variable-latency req/ack memory handshake. Produces a pipeline stall while any requester waits. Sits between the fetch stage, the load/store path and the memory wrapper.

## Interface
- ADDR_W, 9, word address width
- DATA_W, 32, data width
- TIMEOUT, 15, max cycles waiting for mem_ack (used only with the watchdog)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request, held until if_valid
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_rdata  out  DATA_W  fetched word, valid with if_valid
- if_valid  out  1  one-cycle completion pulse to IF
- ls_req  in  1  load/store request (MemRead|MemWrite), held until ls_valid
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  ADDR_W  data address
- ls_wdata  in  DATA_W  store data
- ls_rdata  out  DATA_W  load data, valid with ls_valid; 0 for stores
- ls_valid  out  1  one-cycle completion pulse to LS
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- mem_ack  in  1  memory completion, sampled only while mem_req=1
- stall  out  1  (if_req & ~if_valid) | (ls_req & ~ls_valid), combinational
- err  out  1  timeout pulse, coincident with the aborted valid

## Operation
- States: IDLE, MEM, RESP.
- IDLE: if ls_req, grant LS; else if if_req, grant IF; else stay. On grant, latch we/addr/wdata into mem_* registers, set mem_req, go MEM.
- LS strictly beats IF; simultaneous requests -> LS first, IF at the next IDLE. LS asserts at most once per instruction, so IF starvation is bounded.
- IF grants always drive mem_we=0.
- MEM: hold mem_* stable. On mem_ack, capture mem_rdata (0 if write), clear mem_req, go RESP.
- RESP: pulse the granted requester's valid and drive its rdata for one cycle; go IDLE. The requester drops req on valid; IDLE never sees a stale req.
- rdata outputs hold their value outside valid; content is don't-care.
- mem_ack in IDLE/RESP is ignored.

## Timing
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_valid=0, ls_valid=0, if_rdata=0, ls_rdata=0, err=0, state IDLE, grant none.
- Request in IDLE at cycle 0 -> mem_req=1 from cycle 1.
- mem_ack at cycle k (k≥1) -> valid at cycle k+1 -> IDLE at k+2. Minimum req-to-valid is 2 cycles; back-to-back grants are 3 cycles apart.
- mem_ack may arrive in the first MEM cycle.
- Reset asserted mid-transaction: all outputs return to reset values immediately. A late mem_ack after reset is ignored. No valid is issued for the aborted access.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - Cycle counter of width $clog2(TIMEOUT+1) clears on entry to MEM and increments each MEM cycle without ack.
  - If the counter reaches TIMEOUT with no ack: clear mem_req, go RESP, return rdata=0, pulse err with valid.
  - An ack in the same cycle the counter reaches TIMEOUT wins: normal completion, no err.
- MEM_ARB_TIMEOUT_EN undefined: MEM waits indefinitely, err tied 0, no counter.

## Structure
- Package mem_arb_pkg:
  - typedef enum arb_state_e {IDLE, MEM, RESP}
  - typedef enum grant_e {GNT_NONE, GNT_IF, GNT_LS}
  - default ADDR_W/DATA_W localparams
- Sub-module mem_arb_watchdog (counter plus expiry flag), instantiated only under MEM_ARB_TIMEOUT_EN.

## Test plan
- Single load: ls_req=1, ls_we=0, ls_addr=0x010, memory acks 1 cycle after mem_req with 0xDEADBEEF -> mem_req high 1 cycle, ls_valid at cycle 2 with ls_rdata=0xDEADBEEF, stall high cycles 0-1.
- Collision: if_req and ls_req (store 0x12345678 @0x020) in the same cycle -> store issued first with mem_we=1, ls_valid, ls_rdata=0; then fetch with mem_we=0, if_valid 3 cycles after ls_valid.
- Variable latency: ack delayed 7 cycles -> mem_addr/mem_we/mem_wdata stable for all 7 cycles, valid exactly 1 cycle after ack.
- Spurious ack: mem_ack pulsed in IDLE with no requests -> no valid, state unchanged.
- Reset mid-MEM: reset at cycle 3 of a fetch, then ack at cycle 4 -> mem_req=0 immediately, no if_valid; next if_req is served normally.
- Timeout (macro on, TIMEOUT=15): memory never acks -> mem_req drops after 15 MEM cycles, valid and err pulse together with rdata=0. With the macro off, the same stimulus leaves mem_req high indefinitely and err=0.
